// File: rtl/rvfi_order_sequencer.sv
// Reorders out-of-order RVFI retirements into a single strictly in-order stream.
// Entries are parked in a DEPTH-slot window indexed by the low order bits and drained one per cycle.
module rvfi_order_sequencer #(
  parameter int unsigned NRET  = 1,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [64*NRET-1:0]        rvfi_order,
  input  logic [XLEN*NRET-1:0]      rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]      rvfi_pc_wdata,
  output logic                      out_valid,
  output logic [63:0]               out_order,
  output logic [XLEN-1:0]           out_pc_rdata,
  output logic [XLEN-1:0]           out_pc_wdata,
  output logic [$clog2(DEPTH):0]    out_fill,
  output logic                      out_error
);

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam logic [IDXW:0] FILL_ONE = 1;

  logic [63:0]      r_next;
  logic [DEPTH-1:0] r_used;
  logic [XLEN-1:0]  r_pc_rd [DEPTH];
  logic [XLEN-1:0]  r_pc_wd [DEPTH];

  logic             r_out_valid;
  logic [63:0]      r_out_order;
  logic [XLEN-1:0]  r_out_rd;
  logic [XLEN-1:0]  r_out_wd;
  logic [IDXW:0]    r_fill;
  logic             r_error;

  logic [IDXW-1:0]  w_head;
  logic             w_drain;
  logic [NRET-1:0]  w_acc;
  logic [NRET-1:0]  w_rej;
  logic [IDXW-1:0]  w_idx [NRET];
  logic [IDXW:0]    w_acc_cnt;
  logic [IDXW:0]    w_drain_cnt;

  assign w_head      = r_next[IDXW-1:0];
  assign w_drain     = r_used[w_head];
  assign w_drain_cnt = w_drain ? FILL_ONE : '0;

  // Window test is done in 65 bits so next_order+DEPTH never wraps; the claim
  // mask starts from the pre-edge used bits, so the draining head slot and
  // same-cycle duplicates from higher channels are both rejected.
  always_comb begin
    logic [DEPTH-1:0] v_claim;
    logic [64:0]      v_ord;
    logic [64:0]      v_lo;
    logic [64:0]      v_hi;
    v_claim   = r_used;
    w_acc     = '0;
    w_rej     = '0;
    w_acc_cnt = '0;
    w_idx     = '{default: '0};
    v_lo      = {1'b0, r_next};
    v_hi      = v_lo + 65'(DEPTH);
    v_ord     = '0;
    for (int unsigned c = 0; c < NRET; c++) begin
      v_ord    = {1'b0, rvfi_order[c*64 +: 64]};
      w_idx[c] = v_ord[IDXW-1:0];
      if (rvfi_valid[c]) begin
        if ((v_ord >= v_lo) && (v_ord < v_hi) && !v_claim[w_idx[c]]) begin
          w_acc[c]          = 1'b1;
          v_claim[w_idx[c]] = 1'b1;
          w_acc_cnt         = w_acc_cnt + FILL_ONE;
        end else begin
          w_rej[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_next      <= '0;
      r_used      <= '0;
      r_out_valid <= 1'b0;
      r_out_order <= '0;
      r_out_rd    <= '0;
      r_out_wd    <= '0;
      r_fill      <= '0;
      r_error     <= 1'b0;
    end else begin
      r_out_valid <= w_drain;
      if (w_drain) begin
        r_out_order    <= r_next;
        r_out_rd       <= r_pc_rd[w_head];
        r_out_wd       <= r_pc_wd[w_head];
        r_used[w_head] <= 1'b0;
        r_next         <= r_next + 64'd1;
      end
      for (int unsigned c = 0; c < NRET; c++) begin
        if (w_acc[c]) begin
          r_used[w_idx[c]] <= 1'b1;
        end
      end
      r_fill  <= r_fill + w_acc_cnt - w_drain_cnt;
      r_error <= r_error | (|w_rej);
    end
  end

  // Payload storage needs no reset: a slot is only read while its used bit is set.
  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < NRET; c++) begin
      if (resetn && w_acc[c]) begin
        r_pc_rd[w_idx[c]] <= rvfi_pc_rdata[c*XLEN +: XLEN];
        r_pc_wd[w_idx[c]] <= rvfi_pc_wdata[c*XLEN +: XLEN];
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_order    = r_out_order;
  assign out_pc_rdata = r_out_rd;
  assign out_pc_wdata = r_out_wd;
  assign out_fill     = r_fill;
  assign out_error    = r_error;

endmodule

// File: doc/rvfi_order_sequencer.md
RVFI_ORDER_SEQUENCER -- requirements
Module: rvfi_order_sequencer

Interface
REQ-001 SHALL have parameter NRET, default 1, number of retirement channels in.
REQ-002 SHALL have parameter XLEN, default 32, PC width.
REQ-003 SHALL have parameter DEPTH, default 8, reorder slots; power of two, >= 2.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rvfi_valid  input  NRET  per-channel retire strobe.
REQ-007 SHALL have port rvfi_order  input  64*NRET  per-channel instruction index; channel c at bits [c*64 +: 64].
REQ-008 SHALL have port rvfi_pc_rdata  input  XLEN*NRET  per-channel PC of retired instruction.
REQ-009 SHALL have port rvfi_pc_wdata  input  XLEN*NRET  per-channel next PC.
REQ-010 SHALL have port out_valid  output  1  one in-order retirement this cycle.
REQ-011 SHALL have port out_order  output  64  order of emitted retirement.
REQ-012 SHALL have port out_pc_rdata  output  XLEN  emitted PC.
REQ-013 SHALL have port out_pc_wdata  output  XLEN  emitted next PC.
REQ-014 SHALL have port out_fill  output  clog2(DEPTH)+1  occupied slot count.
REQ-015 SHALL have port out_error  output  1  sticky protocol-violation flag.

Function
REQ-016 SHALL hold register next_order (64 bit), DEPTH slots each {used, pc_rdata, pc_wdata}, slot index = order[clog2(DEPTH)-1:0].
REQ-017 SHALL, per valid channel per edge, accept the entry iff next_order <= order < next_order+DEPTH (65-bit unsigned compare, no wrap) and the target slot is unused; accepted entry sets used and stores both PCs.
REQ-018 SHALL, for a rejected entry (below window, at/above window, slot already used), drop it and set out_error.
REQ-019 SHALL resolve two valid channels with equal order in one cycle by accepting the lowest channel index and flagging the others as errors.
REQ-020 SHALL, on each edge where slot[next_order] was used before the edge, register out_valid=1, out_order=next_order, both PCs from that slot, clear the slot, increment next_order; otherwise register out_valid=0 with other out_* fields holding their last values.
REQ-021 SHALL emit at most one retirement per cycle; throughput is one per cycle when in order.
REQ-022 SHALL have latency: entry sampled at edge k emits at edge k+1 at the earliest (out_valid high in the cycle after edge k+1).
REQ-023 SHALL evaluate the window of REQ-017 against next_order before the edge; an entry for order next_order+DEPTH presented while slot[next_order] drains is rejected.
REQ-024 SHALL update out_fill each edge as previous + accepted - drained; it never exceeds DEPTH.
REQ-025 SHALL keep out_error set once set until reset; acceptance and draining continue after an error.
REQ-026 SHALL never emit a gap: a missing order stalls output indefinitely, with no timeout.

Reset
REQ-027 SHALL, on resetn low, asynchronously clear next_order, all used bits, out_valid, out_order, out_pc_rdata, out_pc_wdata, out_fill and out_error to 0.
REQ-028 SHALL discard buffered entries on reset mid-operation; the first post-reset expected order is 0.
REQ-029 SHALL ignore rvfi_* inputs while resetn is low.

Verification
REQ-030 SHALL pass: NRET=1, orders 0,1,2 on consecutive cycles with pc_rdata 0x0/0x4/0x8 -> out_valid on three consecutive cycles starting two edges after first input, out_order 0,1,2, out_error 0.
REQ-031 SHALL pass: NRET=2, cycle0 ch0=order1 and ch1=order0 -> order 0 emitted, then order 1 on the next cycle, out_fill peaks at 2.
REQ-032 SHALL pass: DEPTH=8, next_order=0, present order 8 -> out_error=1, nothing emitted, out_fill stays 0.
REQ-033 SHALL pass: order 3 presented twice (separate cycles, before drain) -> out_error=1, order 3 emitted once with the first PC values.
REQ-034 SHALL pass: orders 1..7 buffered, order 0 withheld -> out_valid stays 0 and out_fill=7; then order 0 -> orders 0..7 emitted on eight consecutive cycles.
REQ-035 SHALL pass: resetn pulsed low with out_fill=3 -> all outputs 0 immediately; subsequent order 0 accepted and emitted without error.
